// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Purpose : Shared op-code values and the multiply FSM state encoding used by
//           alu_mc and by anything binding checkers onto it.
// Ports   : none (package)
// Config  : ALU_MC_MUL_EN selects whether alu_mc implements op 111 (MUL);
//           the encodings below are present in either build.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/addsub_n.sv
// -----------------------------------------------------------------------------
// addsub_n
// Purpose : WIDTH-bit adder/subtractor. Subtraction is A + ~B + 1, so cout_o
//           is the carry out of that sum (1 means no borrow).
// Ports   : a_i, b_i   operands
//           sub_i      1 = subtract, 0 = add
//           sum_o      low WIDTH bits of the sum
//           cout_o     carry out
//           ovf_o      two's-complement overflow
// -----------------------------------------------------------------------------
module addsub_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = sub_i ? ~b_i : b_i;

    // sub_i doubles as the +1 carry-in of the two's-complement subtract.
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};

    // Overflow: both addends share a sign and the sum's sign differs from it.
    assign ovf_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Purpose : Small ALU with a registered result and flags, a tri-state bus
//           driver and an optional multi-cycle shift-add multiplier.
// Config  : `define ALU_MC_MUL_EN to build the multiplier (op 111) and its
//           IDLE/MUL/FIN FSM. Without it op 111 is a one-cycle no-op that
//           pulses done and leaves result and flags untouched.
// Ports   : clk, reset      clock; asynchronous active-high reset
//           start, op       request (sampled only while busy=0) and op code
//           reg_a, reg_b    operands, captured at the accepting edge
//           enable_output   drives the result register onto bus
//           bus             result when enabled, otherwise all Z
//           busy            multiply in progress
//           done            one-cycle pulse: result and flags valid
//           CF, ZF, NF, VF  registered carry/zero/negative/overflow flags
// Handshake: an operation is accepted on a rising edge where start=1 and
//           busy=0. done is high for exactly the one cycle that follows the
//           edge at which result and flags were written; there is no queuing,
//           so start seen while busy=1 is dropped.
// -----------------------------------------------------------------------------
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic             enable_output,
    output logic [WIDTH-1:0] bus,
    output logic             busy,
    output logic             done,
    output logic             CF,
    output logic             ZF,
    output logic             NF,
    output logic             VF
);

    logic [WIDTH-1:0] result_q;
    logic             cf_q, zf_q, nf_q, vf_q;
    logic             done_q;

    // Single-cycle datapath, evaluated on the live operands at the accepting edge.
    logic [WIDTH-1:0] as_sum;
    logic             as_cout, as_ovf;
    logic [WIDTH-1:0] res_d;
    logic             cf_d, vf_d;

    addsub_n #(.WIDTH(WIDTH)) u_addsub (
        .a_i    (reg_a),
        .b_i    (reg_b),
        .sub_i  (op == OP_SUB),
        .sum_o  (as_sum),
        .cout_o (as_cout),
        .ovf_o  (as_ovf)
    );

    always_comb begin
        res_d = result_q;
        cf_d  = 1'b0;
        vf_d  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res_d = as_sum;
                cf_d  = as_cout;
                vf_d  = as_ovf;
            end
            OP_AND: res_d = reg_a & reg_b;
            OP_OR:  res_d = reg_a | reg_b;
            OP_XOR: res_d = reg_a ^ reg_b;
            OP_SHL: begin
                res_d = {reg_a[WIDTH-2:0], 1'b0};
                cf_d  = reg_a[WIDTH-1];
            end
            OP_SHR: begin
                res_d = {1'b0, reg_a[WIDTH-1:1]};
                cf_d  = reg_a[0];
            end
            default: ; // OP_MUL never writes through this path
        endcase
    end

`ifdef ALU_MC_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic               busy_q;
    logic [WIDTH-1:0]   mcand_q;
    // Upper half accumulates partial sums, lower half holds the shrinking
    // multiplier; after WIDTH steps the whole register is the product.
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_next;

    always_comb begin
        step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_next = {step_sum, prod_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            vf_q     <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_MUL: begin
                    prod_q <= prod_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Final step: publish the product at the same edge.
                        state_q  <= ST_FIN;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= prod_next[WIDTH-1:0];
                        cf_q     <= |prod_next[2*WIDTH-1:WIDTH];
                        vf_q     <= |prod_next[2*WIDTH-1:WIDTH];
                        zf_q     <= (prod_next[WIDTH-1:0] == '0);
                        nf_q     <= prod_next[WIDTH-1];
                    end
                end
                default: begin // ST_IDLE and ST_FIN both accept new work
                    state_q <= ST_IDLE;
                    if (start) begin
                        if (op == OP_MUL) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                            mcand_q <= reg_a;
                            prod_q  <= {{WIDTH{1'b0}}, reg_b};
                            cnt_q   <= '0;
                        end else begin
                            done_q   <= 1'b1;
                            result_q <= res_d;
                            cf_q     <= cf_d;
                            vf_q     <= vf_d;
                            zf_q     <= (res_d == '0);
                            nf_q     <= res_d[WIDTH-1];
                        end
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q   <= 1'b0;
            result_q <= '0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            vf_q     <= 1'b0;
        end else begin
            done_q <= start;
            // op 111 only acknowledges; result and flags keep their values.
            if (start && (op != OP_MUL)) begin
                result_q <= res_d;
                cf_q     <= cf_d;
                vf_q     <= vf_d;
                zf_q     <= (res_d == '0);
                nf_q     <= res_d[WIDTH-1];
            end
        end
    end

    assign busy = 1'b0;
`endif

    assign bus  = enable_output ? result_q : {WIDTH{1'bz}};
    assign done = done_q;
    assign CF   = cf_q;
    assign ZF   = zf_q;
    assign NF   = nf_q;
    assign VF   = vf_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam int W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] reg_a;
  logic [W-1:0] reg_b;
  logic         enable_output;
  wire  [W-1:0] bus;
  logic         busy;
  logic         done;
  logic         CF, ZF, NF, VF;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .reg_a         (reg_a),
    .reg_b         (reg_b),
    .enable_output (enable_output),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .CF            (CF),
    .ZF            (ZF),
    .NF            (NF),
    .VF            (VF)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;

  // Reference architectural state: what result and flags should read now.
  logic [W-1:0] m_res;
  logic         m_cf, m_zf, m_nf, m_vf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_res = '0;
    m_cf = 1'b0; m_zf = 1'b0; m_nf = 1'b0; m_vf = 1'b0;
  endtask

  // Behavioural model using integer arithmetic on unsigned/signed values.
  task automatic model_op(input int o, input int a, input int b);
    int r;
    int full;
    int sa, sb;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0;
    case (o)
      0: begin
        full = a + b; r = full % 256;
        m_cf = (full > 255); m_vf = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      1: begin
        full = a + (255 - b) + 1; r = full % 256;
        m_cf = (full > 255); m_vf = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      2: begin r = a & b; m_cf = 0; m_vf = 0; end
      3: begin r = a | b; m_cf = 0; m_vf = 0; end
      4: begin r = a ^ b; m_cf = 0; m_vf = 0; end
      5: begin r = (a * 2) % 256; m_cf = (a >= 128); m_vf = 0; end
      6: begin r = a / 2; m_cf = (a % 2 == 1); m_vf = 0; end
      default: begin
`ifdef ALU_MC_MUL_EN
        full = a * b; r = full % 256;
        m_cf = (full / 256) != 0; m_vf = m_cf;
`else
        return;
`endif
      end
    endcase
    m_res = 8'(r);
    m_zf  = (r == 0);
    m_nf  = (r >= 128);
  endtask

  // Compares every architectural output to the model, including both bus modes.
  task automatic check_state(input string tag);
    enable_output = 1'b0;
    #1;
    check({tag, "_busz"}, {24'h0, bus}, {24'h0, {W{1'bz}}});
    enable_output = 1'b1;
    #1;
    check({tag, "_bus"}, {24'h0, bus}, {24'h0, m_res});
    check({tag, "_cf"}, {31'h0, CF}, {31'h0, m_cf});
    check({tag, "_zf"}, {31'h0, ZF}, {31'h0, m_zf});
    check({tag, "_nf"}, {31'h0, NF}, {31'h0, m_nf});
    check({tag, "_vf"}, {31'h0, VF}, {31'h0, m_vf});
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic run_single(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; reg_a = a; reg_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    reg_a = W'($urandom); reg_b = W'($urandom);  // must not matter after accept
    model_op(int'(o), int'(a), int'(b));
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check_state(tag);
    @(posedge clk); #1;
    check({tag, "_done_clr"}, {31'h0, done}, 32'h0);
  endtask

`ifdef ALU_MC_MUL_EN
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    int n;
    @(negedge clk);
    start = 1'b1; op = 3'b111; reg_a = a; reg_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    reg_a = W'($urandom); reg_b = W'($urandom);
    n = 0;
    while (busy && n < 40) begin
      if (done) check({tag, "_early_done"}, {31'h0, done}, 32'h0);
      if (inject) begin
        start = 1'b1; op = 3'b000;
        reg_a = W'($urandom); reg_b = W'($urandom);
      end
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    model_op(7, int'(a), int'(b));
    check({tag, "_busy_cycles"}, n, W);
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    check_state(tag);
    @(posedge clk); #1;
    check({tag, "_done_clr"}, {31'h0, done}, 32'h0);
    check({tag, "_busy_idle"}, {31'h0, busy}, 32'h0);
  endtask
`endif

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic async_reset(input string tag);
    int dones;
    #1;
    reset = 1'b1;
    enable_output = 1'b1;
    #1;
    model_reset();
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_bus"}, {24'h0, bus}, 32'h0);
    check({tag, "_flags"}, {28'h0, CF, ZF, NF, VF}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check({tag, "_no_done"}, dones, 0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    logic [2:0] o;
    reset = 1'b1; start = 1'b0; op = '0; reg_a = '0; reg_b = '0; enable_output = 1'b1;
    model_reset();
    #2;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_bus", {24'h0, bus}, 32'h0);
    check("rst_flags", {28'h0, CF, ZF, NF, VF}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    run_single("add_ff_01", 3'b000, 8'hFF, 8'h01);
    run_single("sub_80_01", 3'b001, 8'h80, 8'h01);
    run_single("sub_01_02", 3'b001, 8'h01, 8'h02);
    run_single("add_12_34", 3'b000, 8'h12, 8'h34);
    run_single("shl_81",    3'b101, 8'h81, 8'h00);
    run_single("shr_01",    3'b110, 8'h01, 8'h00);

`ifdef ALU_MC_MUL_EN
    run_mul("mul_0f_11", 8'h0F, 8'h11, 1'b0);
    run_mul("mul_10_10", 8'h10, 8'h10, 1'b1);
    // Abort a multiply part-way through.
    @(negedge clk);
    start = 1'b1; op = 3'b111; reg_a = 8'hAB; reg_b = 8'hCD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    async_reset("rst_mid_mul");
`else
    run_single("add_12_34b", 3'b000, 8'h12, 8'h34);
    run_single("nop_111",    3'b111, 8'hFF, 8'hFF);
    async_reset("rst_idle");
`endif

    run_single("post_rst_add", 3'b000, 8'h7F, 8'h01);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
`ifdef ALU_MC_MUL_EN
      if (o == 3'b111)
        run_mul("rnd_mul", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      else
        run_single("rnd", o, W'($urandom), W'($urandom));
`else
      run_single("rnd", o, W'($urandom), W'($urandom));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
